// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : fetch/data two-port arbiter onto a single backing memory,
//               data-first priority with bounded fetch starvation.
// Revision    : 1.0
// ============================================================================
module mem_arbiter #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  // fetch port
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  output logic          i_stall,
  // data port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          d_stall,
  // backing memory
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GNT_I  = 3'd1,
    GNT_D  = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } state_t;

  localparam logic [2:0] c_starveMax = 3'(STARVE_MAX);

  state_t     r_state;
  state_t     w_stateNext;
  logic [2:0] r_starveCnt;
  logic       w_grantD;
  logic       w_grantI;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_grantD    = 1'b0;
    w_grantI    = 1'b0;
    mem_req     = 1'b0;
    i_ready     = 1'b0;
    d_ready     = 1'b0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        // Data wins unless fetch has already been passed over STARVE_MAX times
        if (d_req && (!i_req || (r_starveCnt < c_starveMax))) begin
          w_grantD    = 1'b1;
          w_stateNext = GNT_D;
        end else if (i_req) begin
          w_grantI    = 1'b1;
          w_stateNext = GNT_I;
        end
      end
      GNT_I: begin
        mem_req = 1'b1;
        if (mem_ack) w_stateNext = RESP_I;
      end
      GNT_D: begin
        mem_req = 1'b1;
        if (mem_ack) w_stateNext = RESP_D;
      end
      RESP_I: begin
        i_ready     = 1'b1;
        w_stateNext = IDLE;
      end
      RESP_D: begin
        d_ready     = 1'b1;
        w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign i_stall = i_req & ~i_ready;
  assign d_stall = d_req & ~d_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starveCnt <= 3'd0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      i_rdata     <= '0;
      d_rdata     <= '0;
    end else begin
      if (w_grantD) begin
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        if (i_req && (r_starveCnt < c_starveMax)) r_starveCnt <= r_starveCnt + 3'd1;
      end
      if (w_grantI) begin
        mem_we      <= 1'b0;
        mem_addr    <= i_addr;
        mem_wdata   <= '0;
        r_starveCnt <= 3'd0;
      end
      if ((r_state == GNT_I) && mem_ack) i_rdata <= mem_rdata;
      // mem_we still holds the granted access type here; stores keep d_rdata
      if ((r_state == GNT_D) && mem_ack && !mem_we) d_rdata <= mem_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : directed scenarios plus randomized traffic for mem_arbiter.
// Revision       : 1.0
// ============================================================================
module tb_mem_arbiter;

  localparam int DW         = 32;
  localparam int AW         = 32;
  localparam int STARVE_MAX = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, d_req, d_we, mem_ack;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          i_ready, i_stall, d_ready, d_stall, mem_req, mem_we, busy;

  int errors = 0;
  int checks = 0;
  bit done   = 1'b0;

  logic [DW-1:0] refMem [0:511];
  logic [DW-1:0] memArr [0:511];
  logic [DW-1:0] lastLoad;

  mem_arbiter #(.DW(DW), .AW(AW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic test_reset();
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    @(negedge clk);
    checks++; if ({mem_req, mem_we, i_ready, d_ready, busy} !== 5'b0)
      begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {mem_req, mem_we, i_ready, d_ready, busy}); end
    checks++; if (mem_addr !== '0 || mem_wdata !== '0)
      begin errors++; $display("FAIL reset_mem: addr %h wdata %h expected 0", mem_addr, mem_wdata); end
    checks++; if (i_rdata !== '0 || d_rdata !== '0)
      begin errors++; $display("FAIL reset_rdata: i %h d %h expected 0", i_rdata, d_rdata); end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_fetch();
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 32'h10;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || i_stall !== 1'b1)
      begin errors++; $display("FAIL fetch_c0: busy %b stall %b expected 0 1", busy, i_stall); end
    @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = 32'h00500093;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h10)
      begin errors++; $display("FAIL fetch_grant: req %b we %b addr %h expected 1 0 10", mem_req, mem_we, mem_addr); end
    @(posedge clk); #1; mem_ack = 1'b0; mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    checks++; if (i_ready !== 1'b1 || d_ready !== 1'b0 || i_rdata !== 32'h00500093)
      begin errors++; $display("FAIL fetch_resp: ready %b rdata %h expected 1 00500093", i_ready, i_rdata); end
    @(posedge clk); #1; i_req = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || i_ready !== 1'b0)
      begin errors++; $display("FAIL fetch_idle: busy %b ready %b expected 0 0", busy, i_ready); end
  endtask

  task automatic test_load_delayed();
    int pulses = 0;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      mem_ack   = (k == 5);
      mem_rdata = (k == 5) ? 32'hCAFEF00D : 32'h0BADF00D;
      @(negedge clk);
      if (d_ready) pulses++;
      checks++; if ({mem_req, d_stall} !== 2'b11 || mem_addr !== 32'h80)
        begin errors++; $display("FAIL load_wait%0d: req %b stall %b addr %h expected 1 1 80", k, mem_req, d_stall, mem_addr); end
    end
    @(posedge clk); #1; mem_ack = 1'b0; mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    if (d_ready) pulses++;
    checks++; if (d_ready !== 1'b1 || d_stall !== 1'b0 || d_rdata !== 32'hCAFEF00D)
      begin errors++; $display("FAIL load_resp: ready %b stall %b rdata %h expected 1 0 cafef00d", d_ready, d_stall, d_rdata); end
    @(posedge clk); #1; d_req = 1'b0;
    repeat (2) begin @(negedge clk); if (d_ready) pulses++; end
    checks++; if (pulses != 1)
      begin errors++; $display("FAIL load_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_priority();
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
    @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = 32'h13572468;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h40)
      begin errors++; $display("FAIL prio_d_grant: req %b we %b addr %h expected 1 1 40", mem_req, mem_we, mem_addr); end
    checks++; if (mem_wdata !== 32'hDEADBEEF)
      begin errors++; $display("FAIL prio_wdata: got %h expected deadbeef", mem_wdata); end
    @(posedge clk); #1; mem_ack = 1'b0;
    @(negedge clk);
    checks++; if (d_ready !== 1'b1 || i_ready !== 1'b0 || d_rdata !== 32'hCAFEF00D)
      begin errors++; $display("FAIL prio_d_resp: dready %b iready %b drdata %h expected 1 0 cafef00d", d_ready, i_ready, d_rdata); end
    @(posedge clk); #1; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL prio_idle: req %b busy %b expected 0 0", mem_req, busy); end
    @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = 32'h11112222;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h20)
      begin errors++; $display("FAIL prio_i_grant: req %b we %b addr %h expected 1 0 20", mem_req, mem_we, mem_addr); end
    @(posedge clk); #1; mem_ack = 1'b0;
    @(negedge clk);
    checks++; if (i_ready !== 1'b1 || d_ready !== 1'b0 || i_rdata !== 32'h11112222 || d_rdata !== 32'hCAFEF00D)
      begin errors++; $display("FAIL prio_i_resp: iready %b irdata %h drdata %h expected 1 11112222 cafef00d", i_ready, i_rdata, d_rdata); end
    @(posedge clk); #1; i_req = 1'b0;
  endtask

  task automatic test_starve();
    logic [5:0] order    = '0;
    logic [5:0] expOrder = 6'b101111;  // grant k at bit k: D,D,D,D,I,D
    logic       prev     = 1'b0;
    int         n = 0, cyc = 0;
    reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    while (n < 6 && cyc < 80) begin
      @(negedge clk); cyc++;
      if (mem_req && !prev) begin order[n] = (mem_addr == 32'h400); n++; end
      prev = mem_req; mem_ack = mem_req; mem_rdata = $urandom;
    end
    checks++; if (n != 6)
      begin errors++; $display("FAIL starve_timeout: got %0d grants expected 6", n); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (order[k] !== expOrder[k])
        begin errors++; $display("FAIL starve_grant%0d: isD %b expected %b", k, order[k], expOrder[k]); end
    end
    @(posedge clk); #1; i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_in_gnt();
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1)
      begin errors++; $display("FAIL rst_gnt_pre: req %b expected 1", mem_req); end
    @(posedge clk); #1; reset = 1'b1; d_req = 1'b0;
    #2;
    checks++; if (mem_req !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL rst_gnt_async: req %b busy %b expected 0 0", mem_req, busy); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if ({busy, mem_req, i_ready, d_ready} !== 4'b0)
        begin errors++; $display("FAIL rst_gnt_after%0d: got %b expected 0000", k, {busy, mem_req, i_ready, d_ready}); end
    end
    checks++; if (d_rdata !== '0 || i_rdata !== '0 || mem_addr !== '0 || mem_we !== 1'b0)
      begin errors++; $display("FAIL rst_gnt_regs: drdata %h irdata %h addr %h we %b expected 0", d_rdata, i_rdata, mem_addr, mem_we); end
    @(posedge clk); #1; mem_ack = 1'b0;
  endtask

  task automatic test_idle_ack();
    @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = 32'h77778888;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if ({busy, mem_req, i_ready, d_ready} !== 4'b0)
        begin errors++; $display("FAIL idle_ack%0d: got %b expected 0000", k, {busy, mem_req, i_ready, d_ready}); end
    end
    @(posedge clk); #1; mem_ack = 1'b0;
  endtask

  // Fetch requester: read-only region, indices 0..255
  task automatic fetchProc(input int n);
    for (int t = 0; t < n; t++) begin
      int idx, cnt;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk); #1;
      idx = $urandom_range(0, 255);
      i_addr = 32'(idx) << 2; i_req = 1'b1;
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (!i_ready && cnt < 100);
      checks++; if (i_ready !== 1'b1 || i_rdata !== refMem[idx])
        begin errors++; $display("FAIL rnd_fetch: ready %b rdata %h expected 1 %h", i_ready, i_rdata, refMem[idx]); end
      @(posedge clk); #1; i_req = 1'b0;
    end
  endtask

  // Data requester: loads/stores on a small window, indices 256..271
  task automatic dataProc(input int n);
    for (int t = 0; t < n; t++) begin
      int idx, cnt;
      logic isStore;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk); #1;
      idx = 256 + $urandom_range(0, 15);
      isStore = 1'($urandom_range(0, 1));
      d_addr = 32'(idx) << 2; d_we = isStore; d_wdata = $urandom; d_req = 1'b1;
      if (isStore) refMem[idx] = d_wdata;
      else         lastLoad    = refMem[idx];
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (!d_ready && cnt < 100);
      checks++; if (d_ready !== 1'b1 || d_rdata !== lastLoad)
        begin errors++; $display("FAIL rnd_data: we %b ready %b rdata %h expected 1 %h", isStore, d_ready, d_rdata, lastLoad); end
      @(posedge clk); #1; d_req = 1'b0;
    end
  endtask

  task automatic responder();
    int waitCnt = 0, lat = 1;
    while (!done) begin
      @(negedge clk);
      if (mem_req) begin
        if (waitCnt == 0) lat = $urandom_range(1, 4);
        waitCnt++;
        mem_rdata = $urandom;
        mem_ack   = (waitCnt == lat);
        if (mem_ack) begin
          if (mem_we) memArr[mem_addr[10:2]] = mem_wdata;
          else        mem_rdata = memArr[mem_addr[10:2]];
        end
      end else begin
        waitCnt = 0; mem_ack = 1'b0; mem_rdata = $urandom;
      end
    end
    mem_ack = 1'b0;
  endtask

  // Reference arbitration: decide from the requests visible in the cycle before mem_req rises
  task automatic monitor();
    logic          prevI = 1'b0, prevD = 1'b0, prevReq = 1'b0, expD, obsD;
    logic [AW-1:0] gAddr = '0;
    int            starve = 0;
    while (!done) begin
      @(negedge clk);
      if (i_ready || d_ready) begin
        checks++; if (i_ready && d_ready)
          begin errors++; $display("FAIL rnd_ready_excl: i %b d %b expected not both", i_ready, d_ready); end
      end
      if (mem_req && !prevReq) begin
        expD = prevD && (!prevI || starve < STARVE_MAX);
        obsD = (mem_addr >= 32'h400);
        checks++; if (obsD !== expD)
          begin errors++; $display("FAIL rnd_grant: isD %b expected %b (starve %0d)", obsD, expD, starve); end
        if (expD) begin
          if (prevI && starve < STARVE_MAX) starve++;
        end else starve = 0;
        gAddr = mem_addr;
      end else if (mem_req) begin
        checks++; if (mem_addr !== gAddr)
          begin errors++; $display("FAIL rnd_addr_stable: got %h expected %h", mem_addr, gAddr); end
      end
      prevI = i_req; prevD = d_req; prevReq = mem_req;
    end
  endtask

  task automatic test_random();
    reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    lastLoad = '0; done = 1'b0;
    fork
      begin
        fork
          fetchProc(40);
          dataProc(40);
        join
        done = 1'b1;
      end
      responder();
      monitor();
    join
  endtask

  initial begin
    for (int k = 0; k < 512; k++) begin
      refMem[k] = 32'h9E3779B9 * 32'(k) + 32'h1234;
      memArr[k] = refMem[k];
    end
    test_reset();
    test_fetch();
    test_load_delayed();
    test_priority();
    test_starve();
    test_reset_in_gnt();
    test_idle_ack();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
